control_command_decoder: RTL and testbench
==========================================

CONTROL_COMMAND_DECODER -- requirements
Module: control_command_decoder

Interface
REQ-001 Parameter HEADER, default 8'hA5, frame start byte.
REQ-002 Parameter CMD_TOGGLE, default 8'h01, only valid command code.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, maximum clk cycles allowed between bytes within a frame; legal range >= 2.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 rx_data  input  8  received serial byte, valid only when rx_valid=1.
REQ-008 rx_valid  input  1  one-cycle strobe per received byte; may arrive on consecutive cycles.
REQ-009 write  output  1  one-cycle pulse commanding a control-register write.
REQ-010 write_register  output  1  value to write; stable from the write pulse until the next write pulse.
REQ-011 frame_error  output  1  one-cycle pulse on a rejected frame.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 Frame SHALL be four bytes in order: HEADER, CMD, DATA, CHECK, with CHECK = CMD xor DATA.
REQ-014 FSM states SHALL be IDLE, GET_CMD, GET_DATA, GET_CHECK; each transition consumes exactly one rx_valid byte.
REQ-015 IDLE: byte == HEADER -> GET_CMD; any other byte SHALL be discarded silently, no frame_error.
REQ-016 GET_CMD: byte latched -> GET_DATA, regardless of value (validated at CHECK).
REQ-017 GET_DATA: byte latched -> GET_CHECK.
REQ-018 GET_CHECK: byte accepted -> IDLE always.
REQ-019 On accepting CHECK with correct checksum and CMD == CMD_TOGGLE, write SHALL pulse high for exactly one cycle on the cycle after the CHECK byte's rx_valid, with write_register = DATA[0] in that same cycle.
REQ-020 On accepting CHECK with checksum mismatch or CMD != CMD_TOGGLE, frame_error SHALL pulse one cycle (same latency as write), write SHALL stay low, write_register SHALL keep its prior value.
REQ-021 write and frame_error SHALL never be high in the same cycle.
REQ-022 Inter-byte timer: reset to 0 on every rx_valid; increments each cycle while state != IDLE; held at 0 in IDLE.
REQ-023 If timer reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle, FSM SHALL return to IDLE and frame_error SHALL pulse the next cycle.
REQ-024 rx_valid in the same cycle as timeout expiry: byte SHALL be processed normally, no timeout.
REQ-025 A HEADER value received in GET_CMD/GET_DATA/GET_CHECK SHALL be treated as ordinary frame data (no resync).
REQ-026 busy SHALL rise the cycle after HEADER accepted and fall the cycle after CHECK accepted or timeout.
REQ-027 Timer width SHALL be $clog2(TIMEOUT_CYCLES) bits minimum; no wrap-around before expiry.
REQ-028 Back-to-back frames with rx_valid every cycle SHALL decode without dropping bytes.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, timer 0, write 0, write_register 0, frame_error 0, busy 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no write or frame_error pulse after release.
REQ-031 First rising clk edge with reset_n high SHALL accept rx_valid normally.

Verification
REQ-032 Bytes A5,01,01,00 -> one write pulse, write_register=1, 1 cycle after last byte; busy high during frame.
REQ-033 Bytes A5,01,00,01 after prior set -> write pulse, write_register=0; then A5,01,01,01 -> frame_error pulse, write_register stays 0.
REQ-034 Bytes A5,02,01,03 -> frame_error pulse (bad CMD), no write; bytes 00,FF in IDLE -> no response.
REQ-035 TIMEOUT_CYCLES=8: A5,01 then silence -> frame_error 8 cycles after last byte, busy falls; byte arriving exactly on expiry cycle -> accepted, no error.
REQ-036 reset_n low after A5,01,01 -> busy 0 asynchronously; after release, byte 00 -> no pulse; full valid frame -> write pulse.
REQ-037 Two valid frames on consecutive-cycle rx_valid (DATA 01 then 00) -> two write pulses 4 cycles apart, write_register 1 then 0.

Source files
------------

// File: rtl/control_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : control_command_decoder
// Purpose  : Decodes four-byte command frames (HEADER, CMD, DATA, CHECK) from
//            a byte stream. A frame with CHECK == CMD ^ DATA and
//            CMD == CMD_TOGGLE produces a one-cycle write pulse carrying
//            DATA[0]. Any other completed frame, or a stall between bytes
//            longer than the timeout, produces a one-cycle frame_error pulse.
// Ports    : clk            - system clock, rising edge
//            reset_n        - asynchronous active-low reset
//            rx_data[7:0]   - received byte, qualified by rx_valid
//            rx_valid       - one-cycle strobe per received byte
//            write          - one-cycle control-register write pulse
//            write_register - value written, held until the next write
//            frame_error    - one-cycle pulse on a rejected or timed-out frame
//            busy           - high while a frame is being collected
// Revision : 1.0 - initial release
// ============================================================================
module control_command_decoder #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  CMD_TOGGLE     = 8'h01,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       write,
  output logic       write_register,
  output logic       frame_error,
  output logic       busy
);

  // The timer only ever needs to reach TIMEOUT_CYCLES-1, so $clog2 bits
  // hold every value it takes without wrapping.
  localparam int unsigned    TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GET_CMD   = 2'd1,
    GET_DATA  = 2'd2,
    GET_CHECK = 2'd3
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         cmd_byte;
  logic [7:0]         data_byte;

  logic expired;
  logic frame_ok;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expired  = (state != IDLE) && !rx_valid && (timer == TIMER_LAST);

  // Evaluated against the byte currently on rx_data, i.e. the CHECK byte
  // when the FSM is in GET_CHECK.
  assign frame_ok = ((cmd_byte ^ data_byte) == rx_data) &&
                    (cmd_byte == CMD_TOGGLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      timer          <= '0;
      cmd_byte       <= 8'h00;
      data_byte      <= 8'h00;
      write          <= 1'b0;
      write_register <= 1'b0;
      frame_error    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Pulses default low; only the cases below raise them for one cycle.
      write       <= 1'b0;
      frame_error <= 1'b0;

      // Inter-byte timer: cleared by every byte, counts while mid-frame,
      // and returns to zero whenever the FSM goes (or stays) idle.
      if (rx_valid || expired || state == IDLE) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      case (state)
        IDLE: begin
          // Non-header bytes are dropped without any indication.
          if (rx_valid && rx_data == HEADER) begin
            state <= GET_CMD;
            busy  <= 1'b1;
          end
        end

        GET_CMD: begin
          // The command is accepted unconditionally here; it is judged
          // together with the checksum once the whole frame is in.
          if (rx_valid) begin
            cmd_byte <= rx_data;
            state    <= GET_DATA;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end

        GET_DATA: begin
          if (rx_valid) begin
            data_byte <= rx_data;
            state     <= GET_CHECK;
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end

        GET_CHECK: begin
          if (rx_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (frame_ok) begin
              write          <= 1'b1;
              write_register <= data_byte[0];
            end else begin
              frame_error <= 1'b1;
            end
          end else if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The two pulses come from mutually exclusive branches above.
  a_pulse_exclusive: assert property (
    @(posedge clk) disable iff (!reset_n) !(write && frame_error));

  // busy is a registered copy of "not IDLE".
  a_busy_tracks_state: assert property (
    @(posedge clk) disable iff (!reset_n) busy == (state != IDLE));

  // The timer is cleared before it could pass its terminal value.
  a_timer_bounded: assert property (
    @(posedge clk) disable iff (!reset_n) timer <= TIMER_LAST);

endmodule
`default_nettype wire

// File: tb/tb_control_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_command_decoder
// Purpose  : Self-checking bench for control_command_decoder. A frame-level
//            model (byte queue plus silent-cycle count) predicts every output
//            each cycle; directed frames add literal expectations, followed
//            by a randomized mix of frames, noise, stalls and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_command_decoder;

  localparam int         TO  = 8;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] CMD = 8'h01;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       write;
  logic       write_register;
  logic       frame_error;
  logic       busy;

  control_command_decoder #(
    .HEADER        (HDR),
    .CMD_TOGGLE    (CMD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .write         (write),
    .write_register(write_register),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Frame-level model: are we inside a frame, which bytes after the header
  // have arrived, and how many cycles since the last byte.
  bit         m_in_frame;
  logic [7:0] m_q[$];
  int         m_silent;
  logic       e_write, e_err, e_reg, e_busy;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".write"},          write,          e_write);
    chk({tag, ".frame_error"},    frame_error,    e_err);
    chk({tag, ".write_register"}, write_register, e_reg);
    chk({tag, ".busy"},           busy,           e_busy);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_silent = 0;
    e_write  = 1'b0;
    e_err    = 1'b0;
    e_reg    = 1'b0;
    e_busy   = 1'b0;
  endtask

  // Outputs expected after the clock edge that sees (v, d).
  task automatic model_clock(input bit v, input logic [7:0] d);
    e_write = 1'b0;
    e_err   = 1'b0;
    if (v) begin
      m_silent = 0;
      if (!m_in_frame) begin
        if (d == HDR) begin
          m_in_frame = 1'b1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 3) begin
          m_in_frame = 1'b0;
          if (((m_q[0] ^ m_q[1]) == m_q[2]) && (m_q[0] == CMD)) begin
            e_write = 1'b1;
            e_reg   = m_q[1][0];
          end else begin
            e_err = 1'b1;
          end
        end
      end
    end else if (m_in_frame) begin
      m_silent++;
      if (m_silent == TO) begin
        m_in_frame = 1'b0;
        e_err      = 1'b1;
      end
    end
    e_busy = m_in_frame;
  endtask

  // One clock cycle: drive on the falling edge, check 1 ns after the rise.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    reset_n  = 1'b1;
    rx_valid = v;
    rx_data  = d;
    model_clock(v, d);
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    step(1'b1, b0);
    step(1'b1, b1);
    step(1'b1, b2);
    step(1'b1, b3);
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    logic [7:0] c, d, k;
    int         mode, gap;

    model_reset();
    #2;
    reset_n = 1'b0;
    #1;
    compare_all("por");
    repeat (2) @(posedge clk);

    // Valid toggle to 1.
    step(1'b1, HDR);
    chk("lit.busy_after_hdr", busy, 1'b1);
    step(1'b1, 8'h01);
    step(1'b1, 8'h01);
    step(1'b1, 8'h00);
    chk("lit.f1_write", write, 1'b1);
    chk("lit.f1_reg", write_register, 1'b1);
    chk("lit.f1_busy", busy, 1'b0);
    chk("pin.model_write", e_write, 1'b1);
    step(1'b0, 8'h00);
    chk("lit.f1_pulse_width", write, 1'b0);

    // Toggle to 0, then bad checksum leaves 0.
    frame(HDR, 8'h01, 8'h00, 8'h01);
    chk("lit.f2_write", write, 1'b1);
    chk("lit.f2_reg", write_register, 1'b0);
    frame(HDR, 8'h01, 8'h01, 8'h01);
    chk("lit.f3_err", frame_error, 1'b1);
    chk("lit.f3_write", write, 1'b0);
    chk("lit.f3_reg", write_register, 1'b0);

    // Bad command, then idle noise.
    frame(HDR, 8'h02, 8'h01, 8'h03);
    chk("lit.f4_err", frame_error, 1'b1);
    chk("lit.f4_write", write, 1'b0);
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    chk("lit.noise_err", frame_error, 1'b0);
    chk("lit.noise_busy", busy, 1'b0);

    // Timeout after A5,01 then silence.
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    repeat (TO - 1) step(1'b0, 8'h00);
    chk("lit.to_not_yet", frame_error, 1'b0);
    chk("lit.to_busy_held", busy, 1'b1);
    step(1'b0, 8'h00);
    chk("lit.to_err", frame_error, 1'b1);
    chk("lit.to_busy_fall", busy, 1'b0);
    chk("pin.model_to_err", e_err, 1'b1);

    // Byte landing on the expiry cycle is accepted.
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    repeat (TO - 1) step(1'b0, 8'h00);
    step(1'b1, 8'h01);
    chk("lit.edge_no_err", frame_error, 1'b0);
    chk("lit.edge_busy", busy, 1'b1);
    step(1'b1, 8'h00);
    chk("lit.edge_write", write, 1'b1);
    chk("lit.edge_reg", write_register, 1'b1);

    // Reset mid-frame.
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    step(1'b1, 8'h01);
    do_reset(2);
    chk("lit.rst_busy", busy, 1'b0);
    chk("lit.rst_reg", write_register, 1'b0);
    step(1'b1, 8'h00);
    chk("lit.rst_no_write", write, 1'b0);
    chk("lit.rst_no_err", frame_error, 1'b0);
    frame(HDR, 8'h01, 8'h01, 8'h00);
    chk("lit.rst_write", write, 1'b1);

    // Back-to-back frames on every cycle.
    frame(HDR, 8'h01, 8'h01, 8'h00);
    chk("lit.b2b_w1", write, 1'b1);
    chk("lit.b2b_r1", write_register, 1'b1);
    step(1'b1, HDR);
    chk("lit.b2b_gap", write, 1'b0);
    step(1'b1, 8'h01);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    chk("lit.b2b_w2", write, 1'b1);
    chk("lit.b2b_r2", write_register, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      mode = $urandom_range(0, 19);
      if (mode < 12) begin
        c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : CMD;
        d = 8'($urandom);
        k = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (c ^ d);
        for (int b = 0; b < 4; b++) begin
          gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2)
                                            : $urandom_range(0, 2);
          repeat (gap) step(1'b0, 8'($urandom));
          case (b)
            0:       step(1'b1, HDR);
            1:       step(1'b1, c);
            2:       step(1'b1, d);
            default: step(1'b1, k);
          endcase
        end
      end else if (mode < 19) begin
        for (int b = 0; b < $urandom_range(1, 4); b++) begin
          step(1'($urandom), ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom));
        end
      end else begin
        do_reset($urandom_range(1, 2));
      end
    end
    step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
